// File: rtl/jtcommando_pkg.sv
// Shared types and constants for the Commando ROM download writer.
// FSM state encoding, PROM bank count/index width, FIFO depth and entry layout.
package jtcommando_pkg;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_REQ,
        ST_ACK
    } prog_st_t;

    localparam int PROM_CNT   = 6;
    localparam int PROM_IDX_W = 3;
    localparam int FIFO_DEPTH = 2;
    localparam int ENTRY_W    = 32;

    typedef struct packed {
        logic [21:0] addr;
        logic [7:0]  data;
        logic [1:0]  mask;
    } prog_entry_t;

endpackage

// File: rtl/jtcommando_prog_fifo.sv
// Two-entry buffer for pending SDRAM byte writes (addr+data+mask).
// Ports: clk, rst_n, push/din, pop/dout (head), full, empty.
module jtcommando_prog_fifo
    import jtcommando_pkg::*;
(
    input  logic               clk,
    input  logic               rst_n,
    input  logic               push,
    input  logic [ENTRY_W-1:0] din,
    input  logic               pop,
    output logic [ENTRY_W-1:0] dout,
    output logic               full,
    output logic               empty
);

    logic [ENTRY_W-1:0] mem [FIFO_DEPTH];
    logic               wr_ptr;
    logic               rd_ptr;
    logic [1:0]         cnt;
    logic               do_push;
    logic               do_pop;

    assign full    = cnt == 2'(FIFO_DEPTH);
    assign empty   = cnt == 2'd0;
    assign do_pop  = pop && !empty;
    // a pop frees the slot the push lands in, so full+pop still accepts
    assign do_push = push && (!full || do_pop);
    assign dout    = mem[rd_ptr];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= 1'b0;
            rd_ptr <= 1'b0;
            cnt    <= 2'd0;
            mem[0] <= '0;
            mem[1] <= '0;
        end else begin
            if (do_push) begin
                mem[wr_ptr] <= din;
                wr_ptr      <= ~wr_ptr;
            end
            if (do_pop) begin
                rd_ptr <= ~rd_ptr;
            end
            case ({do_push, do_pop})
                2'b10:   cnt <= cnt + 2'd1;
                2'b01:   cnt <= cnt - 2'd1;
                default: cnt <= cnt;
            endcase
        end
    end

endmodule

// File: rtl/jtcommando_prog_wr.sv
// ROM download writer: splits the ioctl byte stream into SDRAM writes
// (buffered, ack handshake) and PROM loader strobes.
// Ports: clk, rst_n, downloading, ioctl_addr/data/wr (byte stream in),
// prog_addr/data/mask/we + prog_ack (SDRAM), prom_we/addr/din (PROM),
// busy, ovf (sticky drop flag).
// Macro JTCOMMANDO_PROM_EN enables the PROM path; otherwise every byte
// goes to SDRAM and the PROM outputs are tied low.
module jtcommando_prog_wr
    import jtcommando_pkg::*;
#(
    parameter logic [21:0] PROM_START   = 22'h3_C000,
    parameter logic [21:0] SDRAM_OFFSET = 22'h0
)(
    input  logic                clk,
    input  logic                rst_n,
    input  logic                downloading,
    input  logic [21:0]         ioctl_addr,
    input  logic [7:0]          ioctl_data,
    input  logic                ioctl_wr,
    output logic [21:0]         prog_addr,
    output logic [7:0]          prog_data,
    output logic [1:0]          prog_mask,
    output logic                prog_we,
    input  logic                prog_ack,
    output logic [PROM_CNT-1:0] prom_we,
    output logic [7:0]          prom_addr,
    output logic [3:0]          prom_din,
    output logic                busy,
    output logic                ovf
);

    prog_st_t    st;
    prog_entry_t new_e;
    prog_entry_t head_e;
    logic        wr_ok;
    logic        sdram_hit;
    logic        fifo_push;
    logic        fifo_pop;
    logic        fifo_full;
    logic        fifo_empty;
    logic        dl_q;

    assign wr_ok = downloading && ioctl_wr;

`ifdef JTCOMMANDO_PROM_EN
    logic [10:0]           prom_off;
    logic [PROM_IDX_W-1:0] prom_idx;

    assign sdram_hit = ioctl_addr < PROM_START;
    assign prom_off  = 11'(ioctl_addr - PROM_START);
    assign prom_idx  = prom_off[10:8];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prom_we   <= '0;
            prom_addr <= 8'd0;
            prom_din  <= 4'd0;
        end else begin
            prom_we <= '0;
            // banks 6 and 7 do not exist: dropped without a flag
            if (wr_ok && !sdram_hit &&
                prom_idx < PROM_IDX_W'(PROM_CNT)) begin
                prom_we   <= PROM_CNT'(1) << prom_idx;
                prom_addr <= prom_off[7:0];
                prom_din  <= ioctl_data[3:0];
            end
        end
    end
`else
    assign sdram_hit = 1'b1;
    assign prom_we   = '0;
    assign prom_addr = 8'd0;
    assign prom_din  = 4'd0;
`endif

    assign new_e.addr = (ioctl_addr >> 1) + SDRAM_OFFSET;
    assign new_e.data = ioctl_data;
    assign new_e.mask = {~ioctl_addr[0], ioctl_addr[0]};

    assign fifo_push = wr_ok && sdram_hit;
    assign fifo_pop  = (st == ST_REQ) && prog_ack;

    jtcommando_prog_fifo u_fifo (
        .clk   (clk),
        .rst_n (rst_n),
        .push  (fifo_push),
        .din   (new_e),
        .pop   (fifo_pop),
        .dout  (head_e),
        .full  (fifo_full),
        .empty (fifo_empty)
    );

    assign busy = !fifo_empty || (st != ST_IDLE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            dl_q <= 1'b0;
            ovf  <= 1'b0;
        end else begin
            dl_q <= downloading;
            if (downloading && !dl_q) begin
                ovf <= 1'b0;
            end
            if (fifo_push && fifo_full && !fifo_pop) begin
                ovf <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            st        <= ST_IDLE;
            prog_we   <= 1'b0;
            prog_addr <= 22'd0;
            prog_data <= 8'd0;
            prog_mask <= 2'b11;
        end else begin
            unique case (st)
                ST_IDLE: begin
                    if (!fifo_empty) begin
                        prog_addr <= head_e.addr;
                        prog_data <= head_e.data;
                        prog_mask <= head_e.mask;
                        prog_we   <= 1'b1;
                        st        <= ST_REQ;
                    end
                end
                ST_REQ: begin
                    if (prog_ack) begin
                        prog_we <= 1'b0;
                        st      <= ST_ACK;
                    end
                end
                ST_ACK: begin
                    st <= ST_IDLE;
                end
                default: begin
                    st <= ST_IDLE;
                end
            endcase
        end
    end

endmodule

// File: doc/jtcommando_prog_wr.md
JTCOMMANDO_PROG_WR -- requirements
Module: jtcommando_prog_wr

Interface
REQ-001 SHALL have parameter PROM_START, default 22'h3_C000, the first ioctl byte address of the PROM region.
REQ-002 SHALL have parameter SDRAM_OFFSET, default 22'h0, a word offset added to every SDRAM prog_addr.
REQ-003 SHALL have port clk, input, 1, the system clock (48 MHz); all state on its rising edge.
REQ-004 SHALL have port rst_n, input, 1, the reset, asynchronous and active-low.
REQ-005 SHALL have port downloading, input, 1, high while the ROM download is active.
REQ-006 SHALL have ports ioctl_addr (in, 22), ioctl_data (in, 8) and ioctl_wr (in, 1), the byte stream from the frame; ioctl_wr is a single-cycle strobe.
REQ-007 SHALL have ports prog_addr (out, 22, word address), prog_data (out, 8), prog_mask (out, 2, 1 = lane masked) and prog_we (out, 1), the SDRAM write request.
REQ-008 SHALL have port prog_ack, input, 1, a one-cycle SDRAM completion pulse.
REQ-009 SHALL have ports prom_we (out, 6, one-hot strobe), prom_addr (out, 8) and prom_din (out, 4), the PROM loader.
REQ-010 SHALL have ports busy (out, 1, buffer non-empty or write in flight) and ovf (out, 1, sticky overflow).

Function
REQ-011 SHALL sample ioctl_wr only while downloading=1; strobes while downloading=0 are ignored.
REQ-012 SHALL route a byte with ioctl_addr < PROM_START to the SDRAM path and all other bytes to the PROM path.
REQ-013 SDRAM path: prog_addr = (ioctl_addr>>1) + SDRAM_OFFSET (22-bit wrap); prog_data = ioctl_data; prog_mask = {~a[0], a[0]}.
REQ-014 SDRAM bytes SHALL enter a 2-entry FIFO; a strobe arriving with the FIFO full SHALL be dropped and SHALL set ovf.
REQ-015 FSM states: IDLE, REQ, ACK. IDLE->REQ when the FIFO is non-empty (prog_* loaded from the head, prog_we=1 from the next cycle).
REQ-016 REQ: hold prog_we and prog_* stable; on prog_ack go to ACK with prog_we=0 and pop the head in the same cycle.
REQ-017 ACK: one idle cycle, then IDLE (minimum 3 cycles per SDRAM byte).
REQ-018 A simultaneous push and pop with the FIFO full SHALL succeed without setting ovf.
REQ-019 PROM path: idx = (ioctl_addr-PROM_START)[10:8]; for idx 0..5, prom_we[idx] pulses for exactly one cycle, one cycle after ioctl_wr, with prom_addr = offset[7:0] and prom_din = ioctl_data[3:0].
REQ-020 PROM bytes with idx 6 or 7 SHALL be discarded silently, with no strobe and no ovf.
REQ-021 PROM writes SHALL never wait on prog_ack and are independent of the SDRAM FSM.
REQ-022 On the falling edge of downloading, pending FIFO entries SHALL still be written; busy stays high until the FSM reaches IDLE with the FIFO empty.
REQ-023 ovf SHALL clear only on reset or on the rising edge of downloading.

Reset
REQ-024 rst_n=0 SHALL immediately force: FSM IDLE, FIFO empty, prog_we=0, prog_addr=0, prog_data=0, prog_mask=2'b11, prom_we=0, prom_addr=0, prom_din=0, busy=0, ovf=0.
REQ-025 Reset asserted mid-request SHALL abandon the request; no write is replayed after release.

Configuration
REQ-026 With JTCOMMANDO_PROM_EN defined, the PROM path SHALL be as specified in REQ-019 to REQ-021.
REQ-027 Without JTCOMMANDO_PROM_EN, all bytes SHALL take the SDRAM path and prom_we, prom_addr and prom_din SHALL be tied to 0.

Structure
REQ-028 Package jtcommando_pkg SHALL hold the FSM state enum, the PROM count (6), the PROM index width and the FIFO depth constant.
REQ-029 The 2-entry buffer SHALL be the sub-module jtcommando_prog_fifo (push/pop/full/empty, 32-bit entry: addr+data+mask).

Verification
REQ-030 Write addr 22'h000005, data 8'hA5, ack 4 cycles later -> prog_addr=22'h2, prog_mask=2'b01, prog_data=8'hA5; prog_we high for 4 cycles, then low.
REQ-031 Three strobes on consecutive cycles with prog_ack withheld -> two entries held, ovf=1; first two bytes written in order after acks.
REQ-032 Write PROM_START+22'h0213, data 8'h7C -> prom_we=6'b000100 for one cycle, prom_addr=8'h13, prom_din=4'hC; prog_we stays 0.
REQ-033 downloading falls with 2 entries queued -> both written after acks, busy falls one cycle after the final ACK state.
REQ-034 rst_n pulsed low while in REQ -> prog_we=0 asynchronously, no write after release, ovf=0.
REQ-035 Build without JTCOMMANDO_PROM_EN, write PROM_START+1 -> prog_we request issued, prom_we stays 0.
